// File: rtl/bp_fwd_lin_pipe.sv
// bp_fwd_lin_pipe: masked Boyar-Peralta forward top linear layer, L lanes x d shares,
// computed share-wise (XOR only) and held in a registered valid/ready output stage.
//
// Parameters:
//   d  - share count (masking order + 1)
//   L  - S-box lanes per beat
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - input handshake
//   in_data  [8*d*L]    - bit i of lane l, share s at ((l*8+i)*d+s)
//   out_valid/out_ready - output handshake
//   out_data [27*d*L]   - t_k of lane l, share s at ((l*27+k-1)*d+s)
//   beat_cnt [16]       - completed output transfers, saturating at 0xFFFF
// Build option:
//   BP_FWD_SKID_EN defined   - 2-entry skid buffer (EMPTY/ONE/FULL), registered in_ready
//   BP_FWD_SKID_EN undefined - single output register, in_ready = ~out_valid | out_ready
module bp_fwd_lin_pipe #(
    parameter int d = 2,
    parameter int L = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [8*d*L-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [27*d*L-1:0] out_data,
    output logic [15:0]       beat_cnt
);

    localparam int OW = 27 * d * L;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Linear layer on one share of one byte. Only bits of a single share
    // enter here, so no gate can ever mix share indices.
    function automatic logic [26:0] lin_layer(input logic [7:0] x);
        logic [27:1] t;
        t[1]  = x[7] ^ x[4];
        t[2]  = x[7] ^ x[2];
        t[3]  = x[7] ^ x[1];
        t[4]  = x[4] ^ x[2];
        t[5]  = x[3] ^ x[1];
        t[6]  = t[1] ^ t[5];
        t[7]  = x[6] ^ x[5];
        t[8]  = x[0] ^ t[6];
        t[9]  = x[0] ^ t[7];
        t[10] = t[6] ^ t[7];
        t[11] = x[6] ^ x[2];
        t[12] = x[5] ^ x[2];
        t[13] = t[3] ^ t[4];
        t[14] = t[6] ^ t[11];
        t[15] = t[5] ^ t[11];
        t[16] = t[5] ^ t[12];
        t[17] = t[9] ^ t[16];
        t[18] = x[4] ^ x[0];
        t[19] = t[7] ^ t[18];
        t[20] = t[1] ^ t[19];
        t[21] = x[1] ^ x[0];
        t[22] = t[7] ^ t[21];
        t[23] = t[2] ^ t[22];
        t[24] = t[2] ^ t[10];
        t[25] = t[20] ^ t[17];
        t[26] = t[3] ^ t[16];
        t[27] = t[1] ^ t[12];
        return t;
    endfunction

    logic [OW-1:0] lin_res;

    for (genvar l = 0; l < L; l++) begin : g_lane
        for (genvar s = 0; s < d; s++) begin : g_share
            logic [7:0]  b;
            logic [26:0] t;
            for (genvar i = 0; i < 8; i++) begin : g_in
                assign b[i] = in_data[(l*8+i)*d+s];
            end
            assign t = lin_layer(b);
            for (genvar k = 0; k < 27; k++) begin : g_out
                assign lin_res[(l*27+k)*d+s] = t[k];
            end
        end
    end

    state_t        state_q;
    state_t        state_d;
    logic          in_xfer;
    logic          out_xfer;
    logic [OW-1:0] head_q;
    logic [15:0]   cnt_q;

    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign out_data  = head_q;
    assign beat_cnt  = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) state_d = ONE;
            end
            ONE: begin
`ifdef BP_FWD_SKID_EN
                if (in_xfer && !out_xfer) state_d = FULL;
                else if (!in_xfer && out_xfer) state_d = EMPTY;
`else
                if (!in_xfer && out_xfer) state_d = EMPTY;
`endif
            end
`ifdef BP_FWD_SKID_EN
            FULL: begin
                if (out_xfer) state_d = ONE;
            end
`endif
            default: state_d = EMPTY;
        endcase
    end

`ifdef BP_FWD_SKID_EN
    logic          rdy_q;
    logic [OW-1:0] skid_q;

    // Registered ready: tracks the next state so it equals (state != FULL)
    // on every cycle after reset, and stays low while rst is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= (state_d != FULL);
        end
    end

    assign in_ready = rdy_q;

    // head_q is the oldest beat; skid_q only ever holds the younger one
    // while the stage is FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (state_q == FULL) begin
                if (out_xfer) head_q <= skid_q;
            end else if (in_xfer && (state_q == EMPTY || out_xfer)) begin
                head_q <= lin_res;
            end
            if (in_xfer && state_q == ONE && !out_xfer) begin
                skid_q <= lin_res;
            end
        end
    end
`else
    // Gated by rst so nothing is accepted while the stage is held in reset.
    assign in_ready = ~rst & (~out_valid | out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
        end else if (in_xfer) begin
            head_q <= lin_res;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (out_xfer && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_bp_fwd_lin_pipe.sv
// tb_bp_fwd_lin_pipe: directed bench for bp_fwd_lin_pipe (d=2, L=4) with a
// scoreboard queue of expected output beats and immediate-assertion checks.
module tb_bp_fwd_lin_pipe;

    localparam int D  = 2;
    localparam int LN = 4;
    localparam int IW = 8 * D * LN;
    localparam int OW = 27 * D * LN;
`ifdef BP_FWD_SKID_EN
    localparam int EXP_ACC = 2;
`else
    localparam int EXP_ACC = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [15:0]   beat_cnt;

    logic [OW-1:0] sb[$];
    int            n_chk  = 0;
    int            n_fail = 0;
    int            n_out  = 0;
    logic [15:0]   exp_cnt = '0;

    always #5 clk = ~clk;

    bp_fwd_lin_pipe #(.d(D), .L(LN)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .beat_cnt(beat_cnt)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [26:0] ref_t(input logic [7:0] i);
        logic [27:1] t;
        t[1]  = i[7] ^ i[4];
        t[2]  = i[7] ^ i[2];
        t[3]  = i[7] ^ i[1];
        t[4]  = i[4] ^ i[2];
        t[5]  = i[3] ^ i[1];
        t[6]  = t[1] ^ t[5];
        t[7]  = i[6] ^ i[5];
        t[8]  = i[0] ^ t[6];
        t[9]  = i[0] ^ t[7];
        t[10] = t[6] ^ t[7];
        t[11] = i[6] ^ i[2];
        t[12] = i[5] ^ i[2];
        t[13] = t[3] ^ t[4];
        t[14] = t[6] ^ t[11];
        t[15] = t[5] ^ t[11];
        t[16] = t[5] ^ t[12];
        t[17] = t[9] ^ t[16];
        t[18] = i[4] ^ i[0];
        t[19] = t[7] ^ t[18];
        t[20] = t[1] ^ t[19];
        t[21] = i[1] ^ i[0];
        t[22] = t[7] ^ t[21];
        t[23] = t[2] ^ t[22];
        t[24] = t[2] ^ t[10];
        t[25] = t[20] ^ t[17];
        t[26] = t[3] ^ t[16];
        t[27] = t[1] ^ t[12];
        return t;
    endfunction

    function automatic logic [OW-1:0] golden(input logic [IW-1:0] v);
        logic [OW-1:0] r = '0;
        logic [7:0]    b;
        logic [26:0]   t;
        for (int l = 0; l < LN; l++) begin
            for (int s = 0; s < D; s++) begin
                for (int i = 0; i < 8; i++) b[i] = v[(l*8+i)*D+s];
                t = ref_t(b);
                for (int k = 0; k < 27; k++) r[(l*27+k)*D+s] = t[k];
            end
        end
        return r;
    endfunction

    function automatic logic [26:0] recomb(input logic [OW-1:0] v, input int l);
        logic [26:0] t;
        for (int k = 0; k < 27; k++) begin
            t[k] = v[(l*27+k)*D] ^ v[(l*27+k)*D+1];
        end
        return t;
    endfunction

    task automatic chk(input string tag, input logic [OW-1:0] obs,
                       input logic [OW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int l, input logic [7:0] s0,
                            input logic [7:0] s1);
        for (int i = 0; i < 8; i++) begin
            in_data[(l*8+i)*D]   = s0[i];
            in_data[(l*8+i)*D+1] = s1[i];
        end
    endtask

    task automatic rand_beat();
        logic [7:0] r;
        logic [7:0] x;
        for (int l = 0; l < LN; l++) begin
            r = 8'($urandom);
            x = 8'($urandom);
            set_lane(l, r, x ^ r);
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step(output bit acc);
        bit ix;
        bit ox;
        #1;
        ix = (in_valid === 1'b1) && (in_ready === 1'b1);
        ox = (out_valid === 1'b1) && (out_ready === 1'b1);
        if (ox) begin
            n_out++;
            if (exp_cnt != 16'hFFFF) exp_cnt++;
            if (sb.size() == 0) chk("out_valid_unexpected", out_valid, 1'b0);
            else chk("out_data", out_data, sb.pop_front());
        end
        if (ix) sb.push_back(golden(in_data));
        acc = ix;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        bit acc;
        int guard = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() > 0 && guard < 20) begin
            step(acc);
            guard++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    task automatic send_one();
        bit acc;
        int guard = 0;
        in_valid = 1'b1;
        do begin
            out_ready = ($urandom_range(0, 3) != 0);
            step(acc);
            guard++;
        end while (!acc && guard < 20);
        if (!acc) chk("send_timeout_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        bit            acc;
        int            n_acc;
        int            out0;
        logic [15:0]   cnt0;
        logic [26:0]   t1_exp;
        logic [OW-1:0] sh1_mask;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_beat_cnt", beat_cnt, 16'd0);
        chk("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);

        // Single beat: lane 0 shares 0xA5 / 0xA4 recombine to x = 0x01.
        set_lane(0, 8'hA5, 8'hA4);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step(acc);
        in_valid = 1'b0;
        chk("t1_out_valid", out_valid, 1'b1);
        t1_exp = 27'h07F0180;
        chk("t1_recomb_lane0", recomb(out_data, 0), t1_exp);
        step(acc);
        chk("t1_beat_cnt", beat_cnt, exp_cnt);
        chk("t1_beat_cnt_one", beat_cnt, 16'd1);

        // All 256 bytes over 4 lanes, fresh random share splits.
        for (int b = 0; b < 64; b++) begin
            for (int l = 0; l < LN; l++) begin
                logic [7:0] r;
                r = 8'($urandom);
                set_lane(l, r, 8'(b * LN + l) ^ r);
            end
            send_one();
        end
        drain();

        // Share 1 all zero on the input must give share 1 all zero on the output.
        sh1_mask = '0;
        for (int j = 0; j < 27 * LN; j++) sh1_mask[j*D+1] = 1'b1;
        for (int l = 0; l < LN; l++) set_lane(l, 8'(8'h3C + 8'(l * 77)), 8'h00);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step(acc);
        in_valid = 1'b0;
        chk("share1_zero", out_data & sh1_mask, '0);
        drain();

        // Backpressure: stalled output for 5 cycles with input pending.
        n_acc     = 0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            rand_beat();
            step(acc);
            if (acc) n_acc++;
            if (sb.size() > 0) chk("bp_held_stable", out_data, sb[0]);
        end
        chk("bp_accepted", n_acc, EXP_ACC);
        chk("bp_in_ready", in_ready, 1'b0);
        drain();

        // Simultaneous in/out transfer for 10 cycles from state ONE.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        rand_beat();
        step(acc);
        cnt0 = exp_cnt;
        out0 = n_out;
        for (int c = 0; c < 10; c++) begin
            rand_beat();
            step(acc);
            if (!acc || out_valid !== 1'b1 || in_ready !== 1'b1) begin
                chk("sim_state_one", {acc, out_valid, in_ready}, 3'b111);
            end
        end
        chk("sim_outputs", n_out - out0, 10);
        chk("sim_beat_cnt", beat_cnt, cnt0 + 16'd10);
        drain();

        // Reset while the stage is stalled and holding data.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rand_beat();
            step(acc);
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_out_data", out_data, '0);
        chk("mid_rst_beat_cnt", beat_cnt, 16'd0);
        chk("mid_rst_in_ready", in_ready, 1'b0);
        sb.delete();
        exp_cnt = '0;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(acc);
            chk("no_stale_out", out_valid, 1'b0);
        end

        // Counter saturation from 0xFFFE.
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        exp_cnt = 16'hFFFE;
        #1;
        chk("sat_preload", beat_cnt, exp_cnt);
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rand_beat();
            step(acc);
        end
        drain();
        chk("sat_cnt", beat_cnt, exp_cnt);
        chk("sat_ffff", beat_cnt, 16'hFFFF);
        step(acc);
        chk("sat_hold", beat_cnt, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
